// File: rtl/instr_fetch_pipe_pkg.sv
// Shared constants and slot record for the instruction fetch pipeline.
package instr_fetch_pipe_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned IMEM_ADDR_W = 12;

  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/instr_fetch_pipe_slot_reg.sv
// One fetch pipeline slot: clear beats load, otherwise the slot holds.
module fetch_slot_reg
  import instr_fetch_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  fetch_slot_t i_d,
  output fetch_slot_t o_q
);

  fetch_slot_t r_q;

  // Clear drops only the valid bit; stale payload is never observed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q.valid <= 1'b0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_pipe.sv
// Three-slot instruction fetch stage (issue, data capture, output) between PC update and decode.
module instr_fetch_pipe
  import instr_fetch_pipe_pkg::*;
#(
  parameter int unsigned DATA = INSTR_W,
  parameter int unsigned ADDR = IMEM_ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     PC_in,
  input  logic            GRT_in,
  input  logic            Flush_in,
  input  logic            Stall_in,
  input  logic [DATA-1:0] Mem_rdata,
  output logic            Mem_req,
  output logic [ADDR-1:0] Mem_addr,
  output logic            Fetch_ready,
  output logic            valid_1,
  output logic            valid_2,
  output logic            valid_3,
  output logic [DATA-1:0] Instr_out,
  output logic [31:0]     PC_out
);

  fetch_slot_t r_s1, r_s2, r_s3;
  fetch_slot_t w_s1_d, w_s2_d;
  logic        r_s1_has_data;
  logic        w_adv1, w_adv2, w_adv3;
  logic        w_free1, w_free2, w_free3;
  logic        w_issue, w_capture;
  logic [DATA-1:0] w_s1_instr;

  assign w_adv3  = r_s3.valid && !Stall_in;
  assign w_free3 = !r_s3.valid || w_adv3;
  assign w_adv2  = r_s2.valid && w_free3;
  assign w_free2 = !r_s2.valid || w_adv2;
  assign w_adv1  = r_s1.valid && w_free2;
  assign w_free1 = !r_s1.valid || w_adv1;

  assign Fetch_ready = rst_n && w_free1 && !Flush_in;
  assign Mem_req     = GRT_in && Fetch_ready;
  assign Mem_addr    = PC_in[ADDR+1:2];
  assign w_issue     = Mem_req;

  // Read returns while S1 is blocked: park it in S1's instr field so it survives the stall.
  assign w_capture  = r_s1.valid && !r_s1_has_data && !w_adv1 && !Flush_in;
  assign w_s1_instr = r_s1_has_data ? r_s1.instr : Mem_rdata;

  always_comb begin
    w_s1_d       = '0;
    w_s1_d.valid = 1'b1;
    if (w_issue) begin
      w_s1_d.pc = PC_in;
    end else begin
      w_s1_d.pc    = r_s1.pc;
      w_s1_d.instr = Mem_rdata;
    end
  end

  always_comb begin
    w_s2_d       = '0;
    w_s2_d.valid = 1'b1;
    w_s2_d.pc    = r_s1.pc;
    w_s2_d.instr = w_s1_instr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || Flush_in) begin
      r_s1_has_data <= 1'b0;
    end else if (w_issue) begin
      r_s1_has_data <= 1'b0;
    end else if (w_capture) begin
      r_s1_has_data <= 1'b1;
    end else if (w_adv1) begin
      r_s1_has_data <= 1'b0;
    end
  end

  fetch_slot_reg u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_issue || w_capture),
    .i_clear (Flush_in || (w_adv1 && !w_issue)),
    .i_d     (w_s1_d),
    .o_q     (r_s1)
  );

  fetch_slot_reg u_slot2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_adv1),
    .i_clear (Flush_in || (w_adv2 && !w_adv1)),
    .i_d     (w_s2_d),
    .o_q     (r_s2)
  );

  fetch_slot_reg u_slot3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_adv2),
    .i_clear (Flush_in || (w_adv3 && !w_adv2)),
    .i_d     (r_s2),
    .o_q     (r_s3)
  );

  assign valid_1   = r_s1.valid;
  assign valid_2   = r_s2.valid;
  assign valid_3   = r_s3.valid;
  assign Instr_out = r_s3.instr;
  assign PC_out    = r_s3.pc;

endmodule
